// File: rtl/tag_response_resolver.sv
// -----------------------------------------------------------------------------
// tag_response_resolver
//
// Multiple-response resolver that sits after the CAM tag register bank.
// On a load pulse it snapshots the tag vector (one bit per CAM word) and then
// presents the address of every tagged word, lowest index first, one per
// accepted transfer on a valid/ready stream.  A one-cycle done pulse marks
// the end of a scan; abort cancels a scan silently.
//
// Ports
//   clk              in   1       rising-edge clock
//   rst_n            in   1       asynchronous active-low reset
//   tag_in           in   WORDS   tag vector (bit i = CAM word i)
//   load             in   1       snapshot tag_in and start a scan (IDLE only)
//   abort            in   1       synchronous cancel of the current scan
//   out_valid        out  1       out_addr holds a responder address
//   out_ready        in   1       consumer accepts out_addr this cycle
//   out_addr         out  ADDR_W  lowest pending responder index
//   out_last         out  1       out_addr is the final responder
//   busy             out  1       scan in progress (EMIT or DONE)
//   some_responder   out  1       last accepted snapshot had a bit set
//   responder_count  out  CNT_W   popcount of last accepted snapshot
//   done             out  1       one-cycle pulse at scan end (not on abort)
//
// All outputs come straight from flops.  The next-state logic computes the
// next pending set, and the output flops are loaded from that next set, so
// out_addr/out_last always describe the pending set held in pending_r.
// -----------------------------------------------------------------------------
module tag_response_resolver #(
    parameter int WORDS  = 100,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORDS-1:0]  tag_in,
    input  logic              load,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              some_responder,
    output logic [CNT_W-1:0]  responder_count,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WORDS-1:0] ONE_W  = {{(WORDS-1){1'b0}}, 1'b1};
    localparam logic [WORDS-1:0] ZERO_W = {WORDS{1'b0}};

    // Index of the lowest set bit; zero for an empty vector.  The scan runs
    // high-to-low so the last match written is the lowest one.
    function automatic logic [ADDR_W-1:0] lowest_index(input logic [WORDS-1:0] vec);
        logic [ADDR_W-1:0] idx;
        idx = {ADDR_W{1'b0}};
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[ADDR_W-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Number of set bits in the vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [WORDS-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    function automatic logic single_bit(input logic [WORDS-1:0] vec);
        return (vec != ZERO_W) && ((vec & (vec - ONE_W)) == ZERO_W);
    endfunction

    state_t             state_r, state_nxt_s;
    logic [WORDS-1:0]   pending_r, pending_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               some_r, some_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic [ADDR_W-1:0]  out_addr_r, out_addr_nxt_s;
    logic               out_last_r, out_last_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               transfer_s;

    // A transfer only happens while a responder is being presented.
    always_comb begin
        transfer_s = 1'b0;
        if ((state_r == EMIT) && out_valid_r && out_ready) begin
            transfer_s = 1'b1;
        end else begin
            transfer_s = 1'b0;
        end
    end

    // Next-state, next-pending and snapshot bookkeeping.
    // Priority: abort, then load (IDLE only), then transfer.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        count_nxt_s   = count_r;
        some_nxt_s    = some_r;
        if (abort) begin
            state_nxt_s   = IDLE;
            pending_nxt_s = ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load) begin
                        pending_nxt_s = tag_in;
                        count_nxt_s   = popcount(tag_in);
                        some_nxt_s    = (tag_in != ZERO_W);
                        if (tag_in != ZERO_W) begin
                            state_nxt_s = EMIT;
                        end else begin
                            state_nxt_s = DONE;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                EMIT: begin
                    if (transfer_s) begin
                        // Clear the lowest set bit, i.e. the one just accepted.
                        pending_nxt_s = pending_r & (pending_r - ONE_W);
                        if (out_last_r) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = EMIT;
                        end
                    end else begin
                        state_nxt_s = EMIT;
                    end
                end
                DONE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s   = IDLE;
                    pending_nxt_s = ZERO_W;
                end
            endcase
        end
    end

    // Output values for the next cycle, derived from the next state/pending.
    always_comb begin
        out_valid_nxt_s = 1'b0;
        out_addr_nxt_s  = {ADDR_W{1'b0}};
        out_last_nxt_s  = 1'b0;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        if (state_nxt_s == EMIT) begin
            out_valid_nxt_s = 1'b1;
            out_addr_nxt_s  = lowest_index(pending_nxt_s);
            out_last_nxt_s  = single_bit(pending_nxt_s);
        end else begin
            out_valid_nxt_s = 1'b0;
            out_addr_nxt_s  = {ADDR_W{1'b0}};
            out_last_nxt_s  = 1'b0;
        end
        if (state_nxt_s != IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
        if (state_nxt_s == DONE) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= ZERO_W;
            count_r     <= {CNT_W{1'b0}};
            some_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_addr_r  <= {ADDR_W{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            count_r     <= count_nxt_s;
            some_r      <= some_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_addr_r  <= out_addr_nxt_s;
            out_last_r  <= out_last_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign out_valid       = out_valid_r;
    assign out_addr        = out_addr_r;
    assign out_last        = out_last_r;
    assign busy            = busy_r;
    assign some_responder  = some_r;
    assign responder_count = count_r;
    assign done            = done_r;

endmodule

// File: tb/tb_tag_response_resolver.sv
module tb_tag_response_resolver;

    localparam int WORDS  = 100;
    localparam int ADDR_W = 7;
    localparam int CNT_W  = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WORDS-1:0]  tag_in = '0;
    logic              load = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              some_responder;
    logic [CNT_W-1:0]  responder_count;
    logic              done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tag_response_resolver #(.WORDS(WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tag_in          (tag_in),
        .load            (load),
        .abort           (abort),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_last        (out_last),
        .busy            (busy),
        .some_responder  (some_responder),
        .responder_count (responder_count),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if ({out_valid, out_addr, out_last, busy, some_responder, responder_count, done} !== 17'd0)
            $display("FAIL reset_outputs got v=%0b a=%0d l=%0b b=%0b s=%0b c=%0d d=%0b exp all 0",
                     out_valid, out_addr, out_last, busy, some_responder, responder_count, done);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle got busy=%0b valid=%0b done=%0b exp 0 0 0", busy, out_valid, done);
        else pass_cnt++;
    endtask

    task automatic test_three();
        logic [ADDR_W-1:0] exp_addr [3];
        exp_addr[0] = 7'd3; exp_addr[1] = 7'd17; exp_addr[2] = 7'd99;
        tag_in = '0;
        tag_in[3] = 1'b1; tag_in[17] = 1'b1; tag_in[99] = 1'b1;
        out_ready = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tag_in = '1;  // must not disturb the snapshot
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_addr !== exp_addr[k] || out_last !== (k == 2) || busy !== 1'b1)
                $display("FAIL three_emit%0d got v=%0b a=%0d l=%0b b=%0b exp v=1 a=%0d l=%0b b=1",
                         k, out_valid, out_addr, out_last, busy, exp_addr[k], (k == 2));
            else pass_cnt++;
            total_cnt++;
            if (responder_count !== 7'd3 || some_responder !== 1'b1 || done !== 1'b0)
                $display("FAIL three_count%0d got c=%0d s=%0b d=%0b exp c=3 s=1 d=0",
                         k, responder_count, some_responder, done);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL three_done got d=%0b v=%0b b=%0b exp 1 0 1", done, out_valid, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL three_after got d=%0b b=%0b exp 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_empty();
        tag_in = '0;
        out_ready = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || out_valid !== 1'b0 || some_responder !== 1'b0 || responder_count !== 7'd0)
            $display("FAIL empty_done got d=%0b v=%0b s=%0b c=%0d exp d=1 v=0 s=0 c=0",
                     done, out_valid, some_responder, responder_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL empty_after got d=%0b v=%0b b=%0b exp 0 0 0", done, out_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        tag_in = '0;
        tag_in[0] = 1'b1; tag_in[5] = 1'b1;
        out_ready = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_addr !== 7'd0 || out_last !== 1'b0)
                $display("FAIL bp_hold%0d got v=%0b a=%0d l=%0b exp v=1 a=0 l=0", k, out_valid, out_addr, out_last);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_addr !== 7'd0)
            $display("FAIL bp_before got v=%0b a=%0d exp v=1 a=0", out_valid, out_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_addr !== 7'd5 || out_last !== 1'b1)
            $display("FAIL bp_second got v=%0b a=%0d l=%0b exp v=1 a=5 l=1", out_valid, out_addr, out_last);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b1 || responder_count !== 7'd2)
            $display("FAIL bp_done got d=%0b c=%0d exp d=1 c=2", done, responder_count);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_all_ones();
        int errs;
        errs = 0;
        tag_in = '1;
        out_ready = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_addr !== i[ADDR_W-1:0] || out_last !== (i == WORDS - 1)) begin
                if (errs < 5)
                    $display("FAIL ones_emit%0d got v=%0b a=%0d l=%0b exp v=1 a=%0d l=%0b",
                             i, out_valid, out_addr, out_last, i, (i == WORDS - 1));
                errs++;
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1 || out_valid !== 1'b0 || responder_count !== 7'd100)
            $display("FAIL ones_done got d=%0b v=%0b c=%0d exp d=1 v=0 c=100", done, out_valid, responder_count);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_abort();
        tag_in = '0;
        tag_in[1] = 1'b1; tag_in[2] = 1'b1; tag_in[3] = 1'b1; tag_in[4] = 1'b1;
        out_ready = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        total_cnt++;
        if (out_addr !== 7'd2 || out_valid !== 1'b1)
            $display("FAIL abort_pre got a=%0d v=%0b exp a=2 v=1", out_addr, out_valid);
        else pass_cnt++;
        tick();  // second transfer done; 3 now presented
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || responder_count !== 7'd4)
            $display("FAIL abort_stop got v=%0b b=%0b d=%0b c=%0d exp v=0 b=0 d=0 c=4",
                     out_valid, busy, done, responder_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL abort_nodone got d=%0b v=%0b exp 0 0", done, out_valid);
        else pass_cnt++;
        tag_in = '0;
        tag_in[7] = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_addr !== 7'd7 || out_last !== 1'b1 || responder_count !== 7'd1)
            $display("FAIL abort_reload got v=%0b a=%0d l=%0b c=%0d exp v=1 a=7 l=1 c=1",
                     out_valid, out_addr, out_last, responder_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b1)
            $display("FAIL abort_reload_done got d=%0b exp 1", done);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_while_busy();
        tag_in = '0;
        tag_in[10] = 1'b1; tag_in[20] = 1'b1;
        out_ready = 1'b1;
        load = 1'b1;
        tick();
        tag_in = '0;
        tag_in[50] = 1'b1;  // load stays high during EMIT
        total_cnt++;
        if (out_addr !== 7'd10 || out_valid !== 1'b1)
            $display("FAIL busy_first got a=%0d v=%0b exp a=10 v=1", out_addr, out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_addr !== 7'd20 || out_last !== 1'b1 || responder_count !== 7'd2)
            $display("FAIL busy_second got a=%0d l=%0b c=%0d exp a=20 l=1 c=2", out_addr, out_last, responder_count);
        else pass_cnt++;
        tick();  // DONE cycle, load still high
        total_cnt++;
        if (done !== 1'b1)
            $display("FAIL busy_done got d=%0b exp 1", done);
        else pass_cnt++;
        load = 1'b0;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || responder_count !== 7'd2)
            $display("FAIL busy_idle got b=%0b v=%0b c=%0d exp b=0 v=0 c=2", busy, out_valid, responder_count);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        tag_in = '0;
        tag_in[1] = 1'b1; tag_in[2] = 1'b1; tag_in[3] = 1'b1;
        out_ready = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || responder_count !== 7'd3)
            $display("FAIL areset_pre got v=%0b b=%0b c=%0d exp v=1 b=1 c=3", out_valid, busy, responder_count);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, out_addr, out_last, busy, some_responder, responder_count, done} !== 17'd0)
            $display("FAIL areset_zero got v=%0b a=%0d l=%0b b=%0b s=%0b c=%0d d=%0b exp all 0",
                     out_valid, out_addr, out_last, busy, some_responder, responder_count, done);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL areset_after got d=%0b b=%0b v=%0b exp 0 0 0", done, busy, out_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_three();
        test_empty();
        test_backpressure();
        test_all_ones();
        test_abort();
        test_load_while_busy();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
